// File: rtl/sd_spi_host.sv
// SPI-mode SD card host: dummy clocks, command issue, R1/R3/R7 capture and
// single 512-byte block read, driven by one byte-serial SPI mode-0 engine.
module sd_spi_host #(
  parameter int CLK_DIV    = 2,
  parameter int RESP_POLL  = 8,
  parameter int TOKEN_POLL = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic [31:0] resp_ext,
  output logic        err_timeout,
  output logic        err_token,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  localparam int POLL_MAX = (RESP_POLL > TOKEN_POLL) ? RESP_POLL : TOKEN_POLL;
  localparam int PW       = $clog2(POLL_MAX + 1);

  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [PW-1:0] RESP_LAST  = PW'(RESP_POLL - 1);
  localparam logic [PW-1:0] TOKEN_LAST = PW'(TOKEN_POLL - 1);

  typedef enum logic [3:0] {
    IDLE, DUMMY, CMD, R1WAIT, REXT, TOKWAIT, DATA, CRC, TAIL
  } state_t;

  typedef enum logic [1:0] {OP_DUMMY, OP_R1, OP_R1_EXT, OP_READ} op_t;

  state_t        state;
  op_t           op_q;
  logic [31:0]   arg_q;
  logic [6:0]    crc_q;
  logic [7:0]    div_cnt;
  logic [2:0]    bit_cnt;
  logic [3:0]    byte_cnt;
  logic [PW-1:0] poll_cnt;
  logic [9:0]    data_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic [7:0]    cmd_next;

  // Command byte that follows the one currently on the wire (byte_cnt = index
  // of the byte being sent; byte 0 is loaded straight from cmd_index).
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    cmd_next = 8'hFF;
    case (byte_cnt)
      4'd0:    cmd_next = arg_q[31:24];
      4'd1:    cmd_next = arg_q[23:16];
      4'd2:    cmd_next = arg_q[15:8];
      4'd3:    cmd_next = arg_q[7:0];
      4'd4:    cmd_next = {crc_q, 1'b1};
      default: cmd_next = 8'hFF;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_DUMMY;
      arg_q       <= '0;
      crc_q       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      poll_cnt    <= '0;
      data_cnt    <= '0;
      tx_sr       <= 8'hFF;
      rx_sr       <= 8'hFF;
      sck         <= 1'b0;
      ss          <= 1'b1;
      mosi        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_valid  <= 1'b0;
      err_timeout <= 1'b0;
      err_token   <= 1'b0;
      r1          <= 8'hFF;
      resp_ext    <= '0;
      data_out    <= '0;
    end else begin
      done       <= 1'b0;
      data_valid <= 1'b0;
      if (state == IDLE) begin
        if (cmd_start) begin
          op_q        <= op_t'(cmd_op);
          arg_q       <= cmd_arg;
          crc_q       <= cmd_crc;
          busy        <= 1'b1;
          err_timeout <= 1'b0;
          err_token   <= 1'b0;
          div_cnt     <= '0;
          bit_cnt     <= '0;
          byte_cnt    <= '0;
          poll_cnt    <= '0;
          data_cnt    <= '0;
          if (op_t'(cmd_op) == OP_DUMMY) begin
            state <= DUMMY;
            tx_sr <= 8'hFF;
            mosi  <= 1'b1;
            ss    <= 1'b1;
          end else begin
            state <= CMD;
            tx_sr <= {2'b01, cmd_index};
            mosi  <= 1'b0;
            ss    <= 1'b0;
          end
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (!sck) begin
          // Rising edge: sample miso; a data byte is presented right here.
          sck   <= 1'b1;
          rx_sr <= {rx_sr[6:0], miso};
          if (state == DATA && bit_cnt == 3'd7) begin
            data_valid <= 1'b1;
            data_out   <= {rx_sr[6:0], miso};
          end
        end else if (bit_cnt != 3'd7) begin
          sck     <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          tx_sr   <= {tx_sr[6:0], 1'b1};
          mosi    <= tx_sr[6];
        end else begin
          // Falling edge after bit 7: byte boundary, rx_sr holds the full byte.
          sck     <= 1'b0;
          bit_cnt <= '0;
          tx_sr   <= 8'hFF;
          mosi    <= 1'b1;
          case (state)
            DUMMY: begin
              if (byte_cnt == 4'd9) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
            CMD: begin
              if (byte_cnt == 4'd5) begin
                state    <= R1WAIT;
                byte_cnt <= '0;
                poll_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
                tx_sr    <= cmd_next;
                mosi     <= cmd_next[7];
              end
            end
            R1WAIT: begin
              if (!rx_sr[7]) begin
                r1       <= rx_sr;
                poll_cnt <= '0;
                byte_cnt <= '0;
                case (op_q)
                  OP_R1_EXT: state <= REXT;
                  OP_READ:   state <= (rx_sr == 8'h00) ? TOKWAIT : TAIL;
                  default:   state <= TAIL;
                endcase
              end else if (poll_cnt == RESP_LAST) begin
                err_timeout <= 1'b1;
                r1          <= 8'hFF;
                state       <= TAIL;
              end else begin
                poll_cnt <= poll_cnt + 1'b1;
              end
            end
            REXT: begin
              resp_ext <= {resp_ext[23:0], rx_sr};
              if (byte_cnt == 4'd3) state <= TAIL;
              else byte_cnt <= byte_cnt + 4'd1;
            end
            TOKWAIT: begin
              if (rx_sr == 8'hFE) begin
                state    <= DATA;
                data_cnt <= '0;
              end else if (rx_sr != 8'hFF || poll_cnt == TOKEN_LAST) begin
                err_token <= 1'b1;
                state     <= TAIL;
              end else begin
                poll_cnt <= poll_cnt + 1'b1;
              end
            end
            DATA: begin
              if (data_cnt != 10'd512) data_cnt <= data_cnt + 10'd1;
              if (data_cnt == 10'd511) begin
                state    <= CRC;
                byte_cnt <= '0;
              end
            end
            CRC: begin
              if (byte_cnt == 4'd1) state <= TAIL;
              else byte_cnt <= byte_cnt + 4'd1;
            end
            TAIL: begin
              state <= IDLE;
              ss    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_host.sv
// Scoreboard bench for sd_spi_host: an SD responder model on the SPI pins,
// expected results queued at issue time and checked by an output monitor.
module tb_sd_spi_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        busy, done, err_timeout, err_token, data_valid;
  logic [7:0]  r1, data_out;
  logic [31:0] resp_ext;
  logic        sck, ss, mosi;
  logic        miso = 1'b1;

  sd_spi_host #(.CLK_DIV(2), .RESP_POLL(8), .TOKEN_POLL(1024)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_op(cmd_op),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
    .busy(busy), .done(done), .r1(r1), .resp_ext(resp_ext),
    .err_timeout(err_timeout), .err_token(err_token),
    .data_out(data_out), .data_valid(data_valid),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  r1;
    logic [31:0] ext;
    logic        et;
    logic        ek;
    int          n_data;
    bit          chk_cmd;
    logic [47:0] cmd;
    bit          chk_dummy;
    int          start;
    int          dbase;
    int          dbad;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_data[$];
  logic [7:0] rsp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_total = 0;
  int op_dv = 0;
  int dummy_edges = 0;
  int dummy_mosi_bad = 0;
  int extra_bad = 0;
  logic [47:0] cmd_shift = '0;
  logic [47:0] cmd_log = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] file_byte(input int a);
    return 8'((a * 37) ^ (a >> 3));
  endfunction

  function automatic exp_t mk(input logic [7:0] r, input logic [31:0] x,
                              input logic et, input logic ek, input int nd);
    exp_t e;
    e.r1 = r; e.ext = x; e.et = et; e.ek = ek; e.n_data = nd;
    e.chk_cmd = 1'b0; e.cmd = '0; e.chk_dummy = 1'b0;
    e.start = 0; e.dbase = 0; e.dbad = 0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Dummy-clock observer: sck pulses seen while deselected.
  always @(posedge sck) begin
    if (ss === 1'b1) begin
      dummy_edges++;
      if (mosi !== 1'b1) dummy_mosi_bad++;
    end
  end

  // SD responder: shifts mosi in on rising sck, presents miso after falling
  // sck; replies from rsp_q only after the 6 command bytes have arrived.
  logic [7:0] m_rx = 8'hFF;
  logic [7:0] m_tx = 8'hFF;
  int m_bits = 0;
  int m_bytes = 0;
  always @(posedge sck or negedge sck or posedge ss) begin
    if (ss !== 1'b0) begin
      m_bits = 0; m_bytes = 0; m_tx = 8'hFF; miso = 1'b1;
    end else if (sck === 1'b1) begin
      m_rx = {m_rx[6:0], mosi};
      m_bits++;
    end else if (m_bits == 8) begin
      m_bits = 0;
      if (m_bytes < 6) begin
        cmd_shift = {cmd_shift[39:0], m_rx};
        if (m_bytes == 5) cmd_log = cmd_shift;
      end else if (m_rx !== 8'hFF) begin
        extra_bad++;
      end
      m_bytes++;
      if (m_bytes >= 6 && rsp_q.size() > 0) m_tx = rsp_q.pop_front();
      else m_tx = 8'hFF;
      miso = m_tx[7];
    end else begin
      m_tx = {m_tx[6:0], 1'b1};
      miso = m_tx[7];
    end
  end

  // Monitor: compares every data byte and every completion against the queues.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      op_dv = 0;
    end else begin
      if (data_valid) begin
        dv_total++;
        op_dv++;
        if (exp_data.size() == 0) begin
          checks++; failures++;
          $display("FAIL data_valid: got unexpected byte 0x%0h want no pulse", data_out);
        end else begin
          check("data_out", data_out, exp_data.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done: got unexpected done pulse want none");
        end else begin
          mon_e = exp_q.pop_front();
          check("r1", r1, mon_e.r1);
          check("resp_ext", resp_ext, mon_e.ext);
          check("err_timeout", err_timeout, mon_e.et);
          check("err_token", err_token, mon_e.ek);
          check("data_count", op_dv, mon_e.n_data);
          check("busy_at_done", busy, 1'b0);
          check("ss_at_done", ss, 1'b1);
          check("mosi_idle_bytes", extra_bad, 0);
          if (mon_e.chk_cmd) check("cmd_bytes", cmd_log, mon_e.cmd);
          if (mon_e.chk_dummy) begin
            check("dummy_edges", dummy_edges - mon_e.dbase, 80);
            check("dummy_mosi", dummy_mosi_bad - mon_e.dbad, 0);
            checks++;
            if (cyc - mon_e.start < 320 || cyc - mon_e.start > 322) begin
              failures++;
              $display("FAIL done_latency: got %0d want 321+/-1", cyc - mon_e.start);
            end
          end
        end
        op_dv = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] idx, input logic [31:0] arg,
                       input logic [6:0] crc, input exp_t e);
    @(negedge clk);
    e.start = cyc;
    e.dbase = dummy_edges;
    e.dbad  = dummy_mosi_bad;
    exp_q.push_back(e);
    cmd_op = op; cmd_index = idx; cmd_arg = arg; cmd_crc = crc;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s: got no done within %0d cycles want done", name, budget);
      exp_q.delete();
    end
  endtask

  task automatic push_read_block();
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'hFF);
    rsp_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) begin
      rsp_q.push_back(file_byte(32'h200 + i));
      exp_data.push_back(file_byte(32'h200 + i));
    end
    rsp_q.push_back(8'h12);
    rsp_q.push_back(8'h34);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int base;
    int n;
    rst = 1'b1; cmd_start = 1'b1; cmd_op = 2'd1;
    cmd_index = '0; cmd_arg = '0; cmd_crc = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ss", ss, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b1);
    check("rst_r1", r1, 8'hFF);
    check("rst_resp_ext", resp_ext, 32'h0);
    check("rst_outputs", {done, data_valid, err_timeout, err_token, data_out}, 12'h0);
    rst = 1'b0; cmd_start = 1'b0;
    @(negedge clk);
    check("start_with_rst_ignored", busy, 1'b0);

    // op0: 80 dummy clocks with ss high
    e = mk(8'hFF, 32'h0, 1'b0, 1'b0, 0);
    e.chk_dummy = 1'b1;
    issue(2'd0, 6'd0, 32'h0, 7'h00, e);
    wait_done("op0", 2000);

    // op1: CMD0, one NCR byte then R1=0x01
    rsp_q.push_back(8'hFF); rsp_q.push_back(8'h01);
    e = mk(8'h01, 32'h0, 1'b0, 1'b0, 0);
    e.chk_cmd = 1'b1; e.cmd = 48'h40_00_00_00_00_95;
    issue(2'd1, 6'd0, 32'h0, 7'h4A, e);
    wait_done("op1_cmd0", 2000);

    // op2: CMD8 with R7 echo
    rsp_q.push_back(8'hFF); rsp_q.push_back(8'h01); rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h00); rsp_q.push_back(8'h01); rsp_q.push_back(8'hAA);
    e = mk(8'h01, 32'h0000_01AA, 1'b0, 1'b0, 0);
    e.chk_cmd = 1'b1; e.cmd = 48'h48_00_00_01_AA_87;
    issue(2'd2, 6'd8, 32'h0000_01AA, 7'h43, e);
    wait_done("op2_cmd8", 2000);

    // op3: CMD17 block read of file bytes 0x200..0x3FF
    push_read_block();
    e = mk(8'h00, 32'h0000_01AA, 1'b0, 1'b0, 512);
    e.chk_cmd = 1'b1; e.cmd = 48'h51_00_00_02_00_01;
    issue(2'd3, 6'd17, 32'h0000_0200, 7'h00, e);
    wait_done("op3_read", 40000);

    // op1 with miso stuck high: R1 timeout; a start while busy is ignored
    e = mk(8'hFF, 32'h0000_01AA, 1'b1, 1'b0, 0);
    e.chk_cmd = 1'b1; e.cmd = 48'h77_12_34_56_78_65;
    issue(2'd1, 6'd55, 32'h1234_5678, 7'h32, e);
    repeat (40) @(negedge clk);
    cmd_op = 2'd0; cmd_index = 6'h3F; cmd_arg = 32'hDEAD_BEEF; cmd_crc = 7'h7F;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("busy_ignores_start", busy, 1'b1);
    check("ss_ignores_start", ss, 1'b0);
    wait_done("op1_timeout", 2000);

    // op3 with a bad token
    rsp_q.push_back(8'h00); rsp_q.push_back(8'hFF); rsp_q.push_back(8'h55);
    e = mk(8'h00, 32'h0000_01AA, 1'b0, 1'b1, 0);
    issue(2'd3, 6'd17, 32'h0000_0400, 7'h00, e);
    wait_done("op3_bad_token", 2000);

    // op3 with a non-zero R1: no token wait, no data
    rsp_q.push_back(8'h05);
    e = mk(8'h05, 32'h0000_01AA, 1'b0, 1'b0, 0);
    issue(2'd3, 6'd17, 32'h0000_0600, 7'h00, e);
    wait_done("op3_r1_error", 2000);

    // op3 aborted by reset during data byte 100
    push_read_block();
    e = mk(8'h00, 32'h0000_01AA, 1'b0, 1'b0, 512);
    base = dv_total;
    issue(2'd3, 6'd17, 32'h0000_0200, 7'h00, e);
    n = 0;
    while (dv_total < base + 100 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("bytes_before_rst", dv_total - base, 100);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss", ss, 1'b1);
    check("abort_sck", sck, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    exp_data.delete();
    rsp_q.delete();
    base = dv_total;
    repeat (200) @(negedge clk);
    check("no_data_after_rst", dv_total, base);
    check("abort_r1", r1, 8'hFF);
    check("abort_resp_ext", resp_ext, 32'h0);

    // op1 after the abort completes normally
    rsp_q.push_back(8'h01);
    e = mk(8'h01, 32'h0, 1'b0, 1'b0, 0);
    e.chk_cmd = 1'b1; e.cmd = 48'h40_00_00_00_00_95;
    issue(2'd1, 6'd0, 32'h0, 7'h4A, e);
    wait_done("op1_after_rst", 2000);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
